// File: rtl/if_pc_unit.sv
// Fetch-stage PC unit: fetch PC register, next-address select, held redirects.
// Optional vectored trap entry: define IF_PC_VECTORED_EN.
module if_pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              CAUSE_W      = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               jump,
  input  logic [XLEN-1:0]    jump_target,
  input  logic               e_raised,
  input  logic [XLEN-1:0]    e_handling_addr,
  input  logic               e_interrupt,
  input  logic [CAUSE_W-1:0] e_cause,
  input  logic               mret,
  input  logic [XLEN-1:0]    mepc,
  input  logic               stall,
  input  logic               imem_ready,
  output logic [XLEN-1:0]    pc,
  output logic [XLEN-1:0]    pc4,
  output logic               fetch_valid,
  output logic               flush,
  output logic               redirect_pending,
  output logic               misaligned
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            fv_q, fv_d;
  logic            pend_v_q, pend_v_d;
  logic [1:0]      pend_p_q, pend_p_d;
  logic [XLEN-1:0] pend_t_q, pend_t_d;

  logic            advance;
  logic            live_v;
  logic [1:0]      live_p;
  logic [XLEN-1:0] live_t;
  logic [XLEN-1:0] trap_t;
  logic            take_live;
  logic            sel_v;
  logic [XLEN-1:0] sel_t;

  logic unused_ok;
  assign unused_ok = ^{jump_target[0], mepc[0],
                       e_handling_addr[1:0],
                       e_interrupt, e_cause};

  always_comb begin
    trap_t = {e_handling_addr[XLEN-1:2], 2'b00};
`ifdef IF_PC_VECTORED_EN
    if (e_interrupt)
      trap_t = trap_t + (XLEN'(e_cause) << 2);
`endif
  end

  always_comb begin
    live_v = jump | e_raised | mret;
    live_p = 2'd0;
    live_t = '0;
    priority case (1'b1)
      jump: begin
        live_p = 2'd3;
        live_t = {jump_target[XLEN-1:1], 1'b0};
      end
      e_raised: begin
        live_p = 2'd2;
        live_t = trap_t;
      end
      mret: begin
        live_p = 2'd1;
        live_t = {mepc[XLEN-1:1], 1'b0};
      end
      default: ;
    endcase
  end

  always_comb begin
    advance   = fv_q & ~stall & imem_ready;
    take_live = live_v & (~pend_v_q | (live_p >= pend_p_q));
    sel_v     = live_v | pend_v_q;
    sel_t     = take_live ? live_t : pend_t_q;
    pc4       = pc_q + XLEN'(4);
    pc_d      = pc_q;
    fv_d      = 1'b1;
    pend_v_d  = pend_v_q;
    pend_p_d  = pend_p_q;
    pend_t_d  = pend_t_q;
    if (advance) begin
      pc_d     = sel_v ? sel_t : pc4;
      pend_v_d = 1'b0;
    end else if (take_live) begin
      // Hold the request until fetch can move.
      pend_v_d = 1'b1;
      pend_p_d = live_p;
      pend_t_d = live_t;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_VECTOR;
      fv_q     <= 1'b0;
      pend_v_q <= 1'b0;
      pend_p_q <= 2'd0;
      pend_t_q <= '0;
    end else begin
      pc_q     <= pc_d;
      fv_q     <= fv_d;
      pend_v_q <= pend_v_d;
      pend_p_q <= pend_p_d;
      pend_t_q <= pend_t_d;
    end
  end

  assign pc               = pc_q;
  assign fetch_valid      = fv_q;
  assign redirect_pending = pend_v_q;
  assign flush            = advance & sel_v;
  assign misaligned       = flush & sel_t[1];

endmodule
